// File: rtl/wallace_mac_pkg.sv
// Shared types for the Wallace MAC scheduler: FSM state and operand payload.
package wallace_mac_pkg;

  localparam int unsigned OPND_W = 8;
  localparam int unsigned PROD_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } state_e;

  // One operand pair as presented by a requester
  typedef struct packed {
    logic [OPND_W-1:0] a;
    logic [OPND_W-1:0] b;
    logic              last;
  } opnd_t;

endpackage

// File: rtl/rr_arbiter_lock.sv
// Round-robin pick starting at ptr; when locked, only the locked index may win.
module rr_arbiter_lock #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               lock_en,
  input  logic [ID_W-1:0]    lock_idx,
  output logic [ID_W-1:0]    gnt_idx_c,
  output logic               gnt_vld_c
);

  logic [ID_W-1:0] cand;

  // First valid request at or after ptr, wrapping; lock overrides the search
  always_comb begin
    gnt_idx_c = '0;
    gnt_vld_c = 1'b0;
    cand      = '0;
    if (lock_en) begin
      gnt_idx_c = lock_idx;
      gnt_vld_c = req[lock_idx];
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        cand = ID_W'((32'(ptr) + i) % NUM_REQ);
        if (!gnt_vld_c && req[cand]) begin
          gnt_vld_c = 1'b1;
          gnt_idx_c = cand;
        end
      end
    end
  end

endmodule

// File: rtl/wallace_mac_scheduler.sv
// Shares one external 8x8 multiplier between NUM_REQ requesters, accumulating
// per-burst sums. Optional macro ACC_SAT_EN: saturating accumulation plus a
// sticky sat_flag output; without it the accumulator wraps.
module wallace_mac_scheduler
  import wallace_mac_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ACC_W   = 20,
  parameter int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [OPND_W*NUM_REQ-1:0] req_a,
  input  logic [OPND_W*NUM_REQ-1:0] req_b,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [OPND_W-1:0]         mul_a,
  output logic [OPND_W-1:0]         mul_b,
  input  logic [PROD_W-1:0]         mul_p,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [ACC_W-1:0]          res_data,
  output logic [ID_W-1:0]           res_id,
  output logic                      busy
`ifdef ACC_SAT_EN
  ,
  output logic                      sat_flag
`endif
);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
  opnd_t              opnd_q, opnd_d;
  logic [ID_W-1:0]    gnt_q, gnt_d;
  logic               lock_q, lock_d;
  logic [ID_W-1:0]    lock_id_q, lock_id_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               res_valid_q, res_valid_d;
  logic [ACC_W-1:0]   res_data_q, res_data_d;
  logic [ID_W-1:0]    res_id_q, res_id_d;
  logic               busy_q, busy_d;
  logic [ACC_W-1:0]   acc_sum_c;
  logic [ID_W-1:0]    gnt_idx_c;
  logic               gnt_vld_c;
  opnd_t              opnd_arr [NUM_REQ];

  // Unpack the flat request buses into one operand record per requester
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign opnd_arr[i] = {req_a[OPND_W*i +: OPND_W], req_b[OPND_W*i +: OPND_W], req_last[i]};
  end

  rr_arbiter_lock #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .lock_en   (lock_q),
    .lock_idx  (lock_id_q),
    .gnt_idx_c (gnt_idx_c),
    .gnt_vld_c (gnt_vld_c)
  );

`ifdef ACC_SAT_EN
  localparam int unsigned SUM_W = ACC_W + 1;
  logic [SUM_W-1:0] sum_ext;
  logic             sat_hit_c;
  logic             sat_q, sat_d;

  // Accumulate with one guard bit and clamp to all-ones on carry-out
  always_comb begin
    sum_ext   = SUM_W'(acc_q) + SUM_W'(mul_p);
    sat_hit_c = sum_ext[ACC_W];
    acc_sum_c = sat_hit_c ? '1 : sum_ext[ACC_W-1:0];
  end

  assign sat_flag = sat_q;
`else
  // Wrap-around accumulation
  assign acc_sum_c = acc_q + ACC_W'(mul_p);
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    req_ready_d = '0;
    opnd_d      = opnd_q;
    gnt_d       = gnt_q;
    lock_d      = lock_q;
    lock_id_d   = lock_id_q;
    rr_ptr_d    = rr_ptr_q;
    acc_d       = acc_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
`ifdef ACC_SAT_EN
    sat_d       = sat_q;
`endif
    case (state_q)
      IDLE: begin
        if (gnt_vld_c) begin
          gnt_d       = gnt_idx_c;
          req_ready_d = NUM_REQ'(1) << gnt_idx_c;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        opnd_d    = opnd_arr[gnt_q];
        lock_d    = 1'b1;
        lock_id_d = gnt_q;
        state_d   = CAPTURE;
      end
      CAPTURE: begin
        acc_d = acc_sum_c;
`ifdef ACC_SAT_EN
        sat_d = sat_q | sat_hit_c;
`endif
        if (opnd_q.last) begin
          res_valid_d = 1'b1;
          res_data_d  = acc_sum_c;
          res_id_d    = gnt_q;
          state_d     = DRAIN;
        end else begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          acc_d       = '0;
          lock_d      = 1'b0;
          rr_ptr_d    = (gnt_q == ID_W'(NUM_REQ - 1)) ? '0 : gnt_q + ID_W'(1);
          state_d     = IDLE;
`ifdef ACC_SAT_EN
          sat_d       = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_ready_q <= '0;
      opnd_q      <= '0;
      gnt_q       <= '0;
      lock_q      <= 1'b0;
      lock_id_q   <= '0;
      rr_ptr_q    <= '0;
      acc_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      busy_q      <= 1'b0;
`ifdef ACC_SAT_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      opnd_q      <= opnd_d;
      gnt_q       <= gnt_d;
      lock_q      <= lock_d;
      lock_id_q   <= lock_id_d;
      rr_ptr_q    <= rr_ptr_d;
      acc_q       <= acc_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      busy_q      <= busy_d;
`ifdef ACC_SAT_EN
      sat_q       <= sat_d;
`endif
    end
  end

  assign req_ready = req_ready_q;
  assign mul_a     = opnd_q.a;
  assign mul_b     = opnd_q.b;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_wallace_mac_scheduler.sv
// Bench for wallace_mac_scheduler: exact multiplier stub, cycle model of the
// scheduling rules, and a table of hand-computed burst results.
module tb_wallace_mac_scheduler;

  localparam int unsigned NR = 2;
`ifdef ACC_SAT_EN
  localparam int unsigned AW = 16;
  localparam longint BURST2 = 65535;
`else
  localparam int unsigned AW = 20;
  localparam longint BURST2 = 130150;
`endif
  localparam int unsigned IW = 1;
  localparam int NUM_LIT = 11;
  localparam longint ACC_MOD = longint'(1) << AW;

  logic            clk;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [8*NR-1:0] req_a;
  logic [8*NR-1:0] req_b;
  logic [NR-1:0]   req_last;
  logic [7:0]      mul_a;
  logic [7:0]      mul_b;
  logic [15:0]     mul_p;
  logic            res_valid;
  logic            res_ready;
  logic [AW-1:0]   res_data;
  logic [IW-1:0]   res_id;
  logic            busy;
`ifdef ACC_SAT_EN
  logic            sat_flag;
`endif

  // Exact-product multiplier stub
  assign mul_p = 16'(mul_a) * 16'(mul_b);

  wallace_mac_scheduler #(
    .NUM_REQ (NR),
    .ACC_W   (AW),
    .ID_W    (IW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_last  (req_last),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .busy      (busy)
`ifdef ACC_SAT_EN
    ,
    .sat_flag  (sat_flag)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hand-computed results in the order they must appear
  longint lit_data [NUM_LIT] = '{15, BURST2, 2, 30, 12, 56, 14, 16, 42, 6, 4};
  int     lit_id   [NUM_LIT] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0};

  int n_checks;
  int n_fail;
  int lit_idx;

  // Model state: stage 0 idle, 1 operand handoff, 2 product capture, 3 result held
  int     m_st, m_gnt, m_lk, m_lkid, m_rr, m_last, m_resv, m_resid, m_sat, m_prevv;
  longint m_opa, m_opb, m_sum, m_resd;
  int     exp_rdy;
  bit     found;
  int     idx;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic send_op(input int r, input logic [7:0] a, input logic [7:0] b, input logic last);
    bit got;
    got = 1'b0;
    req_a[r*8 +: 8] = a;
    req_b[r*8 +: 8] = b;
    req_last[r]     = last;
    req_valid[r]    = 1'b1;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      if (req_ready[r]) got = 1'b1;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL grant_timeout req=%0d actual=no_grant required=grant", r);
      req_valid[r] = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      req_valid[r] = 1'b0;
    end
  endtask

  task automatic wait_results(input int target);
    int c;
    c = 0;
    while (lit_idx < target && c < 500) begin
      @(posedge clk);
      c++;
    end
    if (lit_idx < target) begin
      n_checks++;
      n_fail++;
      $display("FAIL result_timeout actual=%0d required=%0d", lit_idx, target);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    lit_idx   = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_last  = '0;
    res_ready = 1'b1;

    // Compare process: model expectations checked on every falling edge
    fork
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          m_st = 0; m_gnt = 0; m_lk = 0; m_lkid = 0; m_rr = 0; m_last = 0;
          m_resv = 0; m_resid = 0; m_sat = 0; m_prevv = 0;
          m_opa = 0; m_opb = 0; m_sum = 0; m_resd = 0;
          chk("reset_outputs", 64'({req_ready, mul_a, mul_b, res_valid, res_data, res_id, busy}), 64'd0);
`ifdef ACC_SAT_EN
          chk("reset_sat_flag", 64'(sat_flag), 64'd0);
`endif
          continue;
        end
        exp_rdy = (m_st == 1) ? (1 << m_gnt) : 0;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("mul_a", 64'(mul_a), 64'(m_opa));
        chk("mul_b", 64'(mul_b), 64'(m_opb));
        chk("res_valid", 64'(res_valid), 64'(m_resv));
        chk("res_data", 64'(res_data), 64'(m_resd));
        chk("res_id", 64'(res_id), 64'(m_resid));
        chk("busy", 64'(busy), 64'(m_st != 0));
`ifdef ACC_SAT_EN
        chk("sat_flag", 64'(sat_flag), 64'(m_sat));
`endif
        if (res_valid && !m_prevv) begin
          if (lit_idx < NUM_LIT) begin
            chk("lit_dut_data", 64'(res_data), 64'(lit_data[lit_idx]));
            chk("lit_dut_id", 64'(res_id), 64'(lit_id[lit_idx]));
            chk("lit_model_data", 64'(m_resd), 64'(lit_data[lit_idx]));
`ifdef ACC_SAT_EN
            chk("lit_sat_flag", 64'(sat_flag), 64'(lit_idx == 1));
`endif
          end else begin
            n_checks++;
            n_fail++;
            $display("FAIL extra_result actual=%0d required=%0d", lit_idx + 1, NUM_LIT);
          end
          lit_idx++;
        end
        m_prevv = int'(res_valid);

        // Advance the model with the inputs the next rising edge will see
        case (m_st)
          0: begin
            if (m_lk != 0) begin
              if (req_valid[m_lkid]) begin
                m_gnt = m_lkid;
                m_st  = 1;
              end
            end else begin
              found = 1'b0;
              for (int k = 0; k < NR; k++) begin
                idx = (m_rr + k) % NR;
                if (!found && req_valid[idx]) begin
                  found = 1'b1;
                  m_gnt = idx;
                  m_st  = 1;
                end
              end
            end
          end
          1: begin
            m_opa  = longint'(req_a[m_gnt*8 +: 8]);
            m_opb  = longint'(req_b[m_gnt*8 +: 8]);
            m_last = int'(req_last[m_gnt]);
            m_lk   = 1;
            m_lkid = m_gnt;
            m_st   = 2;
          end
          2: begin
            m_sum = m_sum + m_opa * m_opb;
`ifdef ACC_SAT_EN
            if (m_sum > ACC_MOD - 1) begin
              m_sum = ACC_MOD - 1;
              m_sat = 1;
            end
`else
            m_sum = m_sum % ACC_MOD;
`endif
            if (m_last != 0) begin
              m_resv  = 1;
              m_resd  = m_sum;
              m_resid = m_gnt;
              m_st    = 3;
            end else begin
              m_st = 0;
            end
          end
          default: begin
            if (res_ready) begin
              m_resv = 0;
              m_sum  = 0;
              m_lk   = 0;
              m_sat  = 0;
              m_rr   = (m_gnt + 1) % NR;
              m_st   = 0;
            end
          end
        endcase
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single one-op burst
    send_op(0, 8'd3, 8'd5, 1'b1);
    wait_results(1);

    // Three-op burst with large products
    send_op(1, 8'd255, 8'd255, 1'b0);
    send_op(1, 8'd255, 8'd255, 1'b0);
    send_op(1, 8'd10, 8'd10, 1'b1);
    wait_results(2);

    // Both requesters competing with single-op bursts
    fork
      begin send_op(0, 8'd1, 8'd2, 1'b1); send_op(0, 8'd3, 8'd4, 1'b1); end
      begin send_op(1, 8'd5, 8'd6, 1'b1); send_op(1, 8'd7, 8'd8, 1'b1); end
    join
    wait_results(6);

    // Locked burst with a stall while the other requester waits
    fork
      begin
        send_op(0, 8'd1, 8'd1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        send_op(0, 8'd2, 8'd2, 1'b0);
        send_op(0, 8'd3, 8'd3, 1'b1);
      end
      send_op(1, 8'd4, 8'd4, 1'b1);
    join
    wait_results(8);

    // Result backpressure
    res_ready = 1'b0;
    fork
      send_op(0, 8'd6, 8'd7, 1'b1);
      send_op(1, 8'd2, 8'd3, 1'b1);
      begin
        for (int c = 0; c < 100 && !res_valid; c++) @(negedge clk);
        repeat (6) @(posedge clk);
        #1;
        res_ready = 1'b1;
      end
    join
    wait_results(10);

    // Reset in the middle of a burst
    req_a[7:0]   = 8'd50;
    req_b[7:0]   = 8'd50;
    req_last[0]  = 1'b0;
    req_valid[0] = 1'b1;
    for (int c = 0; c < 100 && !req_ready[0]; c++) @(negedge clk);
    chk("mid_burst_grant", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    chk("pre_reset_mul_a", 64'(mul_a), 64'd50);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_outputs", 64'({req_ready, mul_a, mul_b, res_valid, res_data, res_id, busy}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_op(0, 8'd2, 8'd2, 1'b1);
    wait_results(11);

    chk("result_count", 64'(lit_idx), 64'(NUM_LIT));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
